// File: rtl/link_rx.sv
`default_nettype none
// ============================================================================
// Module   : link_rx
// Purpose  : Byte-serial link receiver. Samples a strobed 8-bit link,
//            assembles 3-byte frames into 18-bit flits and queues them in a
//            first-word-fall-through FIFO for the router.
// Ports    : CLK, rst            - clock, synchronous active-high reset
//            sync_clk_in         - link strobe, rising edge = one byte
//            serial_data_in[7:0] - link byte
//            flit_out[17:0]      - FIFO head flit (0 when empty)
//            flit_valid          - FIFO non-empty
//            flit_ready          - router pops the head this cycle
//            fifo_count          - FIFO occupancy
//            overflow            - pulse: completed flit dropped, FIFO full
//            frame_err           - pulse: partial frame abandoned on timeout
//            drop_cnt[7:0]       - saturating count of dropped flits
// Revision : 1.0 - initial release
// ============================================================================
module link_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic                          sync_clk_in,
  input  logic [7:0]                    serial_data_in,
  output logic [17:0]                   flit_out,
  output logic                          flit_valid,
  input  logic                          flit_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [7:0]                    drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, B1 = 2'd1, B2 = 2'd2} state_t;

  // --------------------------------------------------------------------------
  // Input sampling. The byte is taken from the first data stage, which lines
  // up with the strobe edge detected between s1 and s2, so a second data
  // stage would never be read.
  // --------------------------------------------------------------------------
  logic       s1, s2;
  logic [7:0] d1;
  logic       strobe;
  logic [7:0] byte_in;

  always_ff @(posedge CLK) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d1 <= 8'h00;
    end else begin
      s1 <= sync_clk_in;
      s2 <= s1;
      d1 <= serial_data_in;
    end
  end

  assign strobe  = s1 & ~s2;
  assign byte_in = d1;

  // --------------------------------------------------------------------------
  // Frame assembly FSM with inter-byte watchdog
  // --------------------------------------------------------------------------
  state_t          state, state_nx;
  logic [WD_W-1:0] wd, wd_nx;
  logic [1:0]      hi, hi_nx;
  logic [7:0]      mid, mid_nx;
  logic            push_req, push_req_nx;
  logic [17:0]     push_data, push_data_nx;
  logic            ferr_nx;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      wd        <= '0;
      hi        <= 2'b00;
      mid       <= 8'h00;
      push_req  <= 1'b0;
      push_data <= 18'h0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      wd        <= wd_nx;
      hi        <= hi_nx;
      mid       <= mid_nx;
      push_req  <= push_req_nx;
      push_data <= push_data_nx;
      frame_err <= ferr_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    wd_nx        = wd;
    hi_nx        = hi;
    mid_nx       = mid;
    push_req_nx  = 1'b0;
    push_data_nx = push_data;
    ferr_nx      = 1'b0;
    case (state)
      IDLE: begin
        wd_nx = '0;
        // Only a byte with bit 1 set can open a frame; trailer/idle bytes
        // have it clear and fall through here.
        if (strobe && byte_in[1]) begin
          hi_nx    = byte_in[1:0];
          state_nx = B1;
        end
      end
      B1, B2: begin
        if (strobe) begin
          wd_nx = '0;
          if (state == B1) begin
            mid_nx   = byte_in;
            state_nx = B2;
          end else begin
            push_req_nx  = 1'b1;
            push_data_nx = {hi, mid, byte_in};
            state_nx     = IDLE;
          end
        end else if (wd == WD_LAST) begin
          // TIMEOUT cycles have passed since the last byte
          wd_nx    = '0;
          ferr_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          wd_nx = wd + WD_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Receive FIFO (first-word-fall-through)
  // --------------------------------------------------------------------------
  logic [17:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, pop, push_ok, drop;

  assign full    = (count == DEPTH_C);
  assign pop     = flit_valid & flit_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= 8'h00;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      overflow <= drop;
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign flit_valid = (count != '0);
  assign fifo_count = count;
  // Masked so the output is defined (zero) while the FIFO is empty or reset.
  assign flit_out   = flit_valid ? mem[rd_ptr] : 18'h0;

endmodule
`default_nettype wire

// File: tb/tb_link_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_rx
// Purpose  : Self-checking bench for link_rx. A queue-based reference model
//            predicts FIFO contents, occupancy, overflow and drop count every
//            cycle; directed scenarios plus randomized frames drive the link.
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 15;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        sync_clk_in = 1'b0;
  logic [7:0]  serial_data_in = 8'h00;
  logic        flit_ready = 1'b0;
  logic [17:0] flit_out;
  logic        flit_valid;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        frame_err;
  logic [7:0]  drop_cnt;

  link_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .CLK            (CLK),
    .rst            (rst),
    .sync_clk_in    (sync_clk_in),
    .serial_data_in (serial_data_in),
    .flit_out       (flit_out),
    .flit_valid     (flit_valid),
    .flit_ready     (flit_ready),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .frame_err      (frame_err),
    .drop_cnt       (drop_cnt)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [17:0] mq[$];       // expected FIFO contents, head first
  logic [17:0] pend_f[$];   // completed frames awaiting their push edge
  int          pend_at[$];  // cycle index of the negedge preceding that edge
  logic [17:0] got_q[$];    // flits actually popped from the DUT
  logic        m_ovf = 1'b0;
  int          m_drop = 0;
  int          ferr_seen = 0, exp_ferr = 0, ovf_seen = 0, n_pop = 0;
  bit          chk_en = 1'b0, rnd_ready = 1'b0;

  always @(negedge CLK) begin : mon
    logic [17:0] f;
    if (chk_en) begin
      check("flit_valid", flit_valid, mq.size() != 0);
      check("fifo_count", fifo_count, mq.size());
      if (mq.size() != 0) check("flit_out", flit_out, mq[0]);
      check("overflow", overflow, m_ovf);
      check("drop_cnt", drop_cnt, m_drop);
      if (frame_err) ferr_seen++;
      if (overflow) ovf_seen++;
      if (flit_valid && flit_ready) begin
        n_pop++;
        got_q.push_back(flit_out);
      end
      // advance the model to the state after the coming rising edge
      if (rst) begin
        mq.delete(); pend_f.delete(); pend_at.delete();
        m_ovf = 1'b0; m_drop = 0;
      end else begin
        if (mq.size() != 0 && flit_ready) void'(mq.pop_front());
        m_ovf = 1'b0;
        if (pend_at.size() != 0 && pend_at[0] == cyc) begin
          f = pend_f.pop_front();
          void'(pend_at.pop_front());
          if (mq.size() < DEPTH) mq.push_back(f);
          else begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK); #1;
    if (rnd_ready) flit_ready = ($urandom_range(0, 3) == 0);
  endtask

  // Rising edge of sync_clk_in now, next rising edge 'gap' cycles later.
  // A flit completes two edges after its byte2 strobe is detected.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit push,
                           input logic [17:0] f);
    serial_data_in = b;
    sync_clk_in    = 1'b1;
    if (push) begin
      pend_f.push_back(f);
      pend_at.push_back(cyc + 2);
    end
    tick();
    sync_clk_in = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic send_frame(input logic [17:0] f, input int g0, input int g1, input int g2);
    send_byte({6'b0, f[17:16]}, g0, 1'b0, f);
    send_byte(f[15:8], g1, 1'b0, f);
    send_byte(f[7:0], g2, 1'b1, f);
  endtask

  // Partial frame (1 or 2 bytes) followed by silence of 'hold' cycles.
  task automatic abandon(input int nbytes, input int hold);
    if (hold > TMO) exp_ferr++;
    if (nbytes == 1) send_byte(8'h03, hold, 1'b0, 18'h0);
    else begin
      send_byte(8'h02, 3, 1'b0, 18'h0);
      send_byte(8'h55, hold, 1'b0, 18'h0);
    end
  endtask

  int p0, o0, e0;
  logic [17:0] rf;

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    tick();
    check("rst_flit_out", flit_out, 0);
    check("rst_valid", flit_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);
    rst = 1'b0;
    repeat (3) tick();

    // single frame with trailer, router always ready
    flit_ready = 1'b1;
    p0 = n_pop;
    send_frame(18'h2A5C3, 2, 2, 2);
    send_byte(8'h00, 2, 1'b0, 18'h0);
    repeat (8) tick();
    check("one_pops", n_pop - p0, 1);
    check("one_flit", got_q[got_q.size()-1], 18'h2A5C3);
    check("one_count", fifo_count, 0);

    // idle bytes in IDLE are ignored
    p0 = n_pop;
    send_byte(8'h00, 3, 1'b0, 18'h0);
    send_byte(8'h01, 3, 1'b0, 18'h0);
    repeat (6) tick();
    check("idle_pops", n_pop - p0, 0);
    check("idle_count", fifo_count, 0);

    // inter-byte gap exactly TIMEOUT is still accepted
    p0 = n_pop; e0 = ferr_seen;
    send_frame(18'h31234, TMO, TMO, 3);
    repeat (6) tick();
    check("gapmax_pops", n_pop - p0, 1);
    check("gapmax_ferr", ferr_seen - e0, 0);

    // timeout after byte1, then a normal frame
    p0 = n_pop; e0 = ferr_seen;
    abandon(2, 40);
    send_frame(18'h2BEEF, 2, 3, 3);
    repeat (6) tick();
    check("tmo_ferr", ferr_seen - e0, 1);
    check("tmo_pops", n_pop - p0, 1);
    check("tmo_flit", got_q[got_q.size()-1], 18'h2BEEF);

    // gap of TIMEOUT+1 after byte0 is a timeout
    e0 = ferr_seen;
    abandon(1, TMO + 1);
    repeat (4) tick();
    check("tmo1_ferr", ferr_seen - e0, 1);

    // fill to full, ninth frame dropped, then drain in order
    flit_ready = 1'b0;
    o0 = ovf_seen;
    for (int i = 0; i < 9; i++) send_frame(18'h20000 + 18'(i), 2, 2, 3);
    repeat (4) tick();
    check("full_count", fifo_count, 8);
    check("full_drop", drop_cnt, 1);
    check("full_ovf", ovf_seen - o0, 1);
    got_q.delete();
    flit_ready = 1'b1;
    repeat (12) tick();
    check("drain_n", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      check("drain_order", got_q[i], 18'h20000 + 18'(i));

    // full FIFO, ninth push coincides with a pop
    flit_ready = 1'b0;
    o0 = ovf_seen;
    for (int i = 0; i < 8; i++) send_frame(18'h30000 + 18'(i), 2, 2, 3);
    send_frame(18'h30008, 2, 2, 2);
    flit_ready = 1'b1;
    tick();
    flit_ready = 1'b0;
    repeat (3) tick();
    check("sim_count", fifo_count, 8);
    check("sim_ovf", ovf_seen - o0, 0);
    check("sim_drop", drop_cnt, 1);
    got_q.delete();
    flit_ready = 1'b1;
    repeat (12) tick();
    check("sim_n", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      check("sim_order", got_q[i], 18'h30001 + 18'(i));

    // reset mid-frame with flits queued
    flit_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(18'h21100 + 18'(i), 2, 2, 3);
    e0 = ferr_seen;
    send_byte(8'h02, 3, 1'b0, 18'h0);
    send_byte(8'hAA, 4, 1'b0, 18'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstm_count", fifo_count, 0);
    check("rstm_valid", flit_valid, 0);
    check("rstm_drop", drop_cnt, 0);
    repeat (3) tick();
    p0 = n_pop;
    flit_ready = 1'b1;
    send_frame(18'h2C0DE, 2, 2, 3);
    repeat (30) tick();
    check("rstm_ferr", ferr_seen - e0, 0);
    check("rstm_pops", n_pop - p0, 1);
    check("rstm_flit", got_q[got_q.size()-1], 18'h2C0DE);

    // randomized traffic
    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0: send_byte(8'($urandom) & 8'hFD, $urandom_range(2, 5), 1'b0, 18'h0);
        1: abandon($urandom_range(1, 2), $urandom_range(TMO + 1, TMO + 6));
        default: begin
          rf = {1'b1, 17'($urandom)};
          send_frame(rf, $urandom_range(2, TMO), $urandom_range(2, TMO),
                     $urandom_range(2, 6));
        end
      endcase
    end
    rnd_ready = 1'b0;
    flit_ready = 1'b1;
    repeat (20) tick();
    check("end_count", fifo_count, 0);
    check("end_ferr", ferr_seen, exp_ferr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
